// File: rtl/dafx_channel_mixer.sv
// Stereo ADC + oscillator mixer with per-channel and output Q-format gains and saturation.
// Latency: right sample accepted in cycle T -> left output valid in cycle T+4; min frame period 7 cycles.
// Backpressure: adc_ready only in the capture states; the output holds data/last stable until dac_ready.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   adc_data/valid/ready/last       ADC stream in, last marks the right word of a frame
//   osc_sample                      free-running mono oscillator, sampled with the right word
//   dac_data/valid/ready/last       DAC stream out, left then right (last=1)
//   cr_mix_channel_gain_0/1/2       gains for ADC left, ADC right, oscillator (Q_BITS_P fraction bits)
//   cr_mix_output_gain              gain applied to each summed channel
//   cmd_clear_clip                  pulse clearing the sticky clip flags
//   sr_mix_channel_clip/out_clip    sticky clip status
//   sr_mix_out_left/right           last emitted stereo frame
module dafx_channel_mixer #(
  parameter int AUDIO_WIDTH_P = 24,
  parameter int GAIN_WIDTH_P  = 16,
  parameter int Q_BITS_P      = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [AUDIO_WIDTH_P-1:0] adc_data,
  input  logic                     adc_valid,
  output logic                     adc_ready,
  input  logic                     adc_last,
  input  logic [AUDIO_WIDTH_P-1:0] osc_sample,
  output logic [AUDIO_WIDTH_P-1:0] dac_data,
  output logic                     dac_valid,
  input  logic                     dac_ready,
  output logic                     dac_last,
  input  logic [GAIN_WIDTH_P-1:0]  cr_mix_channel_gain_0,
  input  logic [GAIN_WIDTH_P-1:0]  cr_mix_channel_gain_1,
  input  logic [GAIN_WIDTH_P-1:0]  cr_mix_channel_gain_2,
  input  logic [GAIN_WIDTH_P-1:0]  cr_mix_output_gain,
  input  logic                     cmd_clear_clip,
  output logic [2:0]               sr_mix_channel_clip,
  output logic                     sr_mix_out_clip,
  output logic [AUDIO_WIDTH_P-1:0] sr_mix_out_left,
  output logic [AUDIO_WIDTH_P-1:0] sr_mix_out_right
);

  localparam int A  = AUDIO_WIDTH_P;
  localparam int G  = GAIN_WIDTH_P;
  localparam int PW = A + G + 1;   // signed sample x zero-extended gain, exact
  localparam int SW = PW + 1;      // sum of two terms, exact
  localparam int OW = SW + G + 1;  // sum x output gain, exact

  typedef enum logic [2:0] {CAP_L, CAP_R, MUL, SUM, OGAIN, OUT_L, OUT_R} state_t;

  // Exact signed x unsigned product followed by an arithmetic shift (floor division by 2^Q).
  function automatic logic [PW-1:0] scale_term(input logic [A-1:0] s, input logic [G-1:0] g);
    logic [PW-1:0] prod;
    prod = {{(PW-A){s[A-1]}}, s} * {{(PW-G){1'b0}}, g};
    return $signed(prod) >>> Q_BITS_P;
  endfunction

  function automatic logic [OW-1:0] scale_out(input logic [SW-1:0] s, input logic [G-1:0] g);
    logic [OW-1:0] prod;
    prod = {{(OW-SW){s[SW-1]}}, s} * {{(OW-G){1'b0}}, g};
    return $signed(prod) >>> Q_BITS_P;
  endfunction

  // A value fits in A signed bits when all bits from the A-bit sign position upward agree.
  function automatic logic fits(input logic [OW-A:0] hi);
    return (&hi) | ~(|hi);
  endfunction

  state_t         r_state, w_next;
  logic           r_started;
  logic [A-1:0]   r_l, r_r, r_osc;
  logic [PW-1:0]  r_tl, r_tr, r_to;
  logic [SW-1:0]  r_sum_l, r_sum_r;
  logic [A-1:0]   r_out_l, r_out_r;
  logic [2:0]     r_ch_clip;
  logic           r_out_clip;
  logic [A-1:0]   r_sr_left, r_sr_right;

  logic           w_adc_fire;
  logic [PW-1:0]  w_term_l, w_term_r, w_term_o;
  logic [2:0]     w_ch_clip;
  logic [OW-1:0]  w_og_l, w_og_r;
  logic           w_clip_l, w_clip_r;
  logic [A-1:0]   w_sat_l, w_sat_r;

  localparam logic [A-1:0] MAX_C = {1'b0, {(A-1){1'b1}}};
  localparam logic [A-1:0] MIN_C = {1'b1, {(A-1){1'b0}}};

  assign w_adc_fire = adc_valid & adc_ready;

  assign w_term_l = scale_term(r_l,   cr_mix_channel_gain_0);
  assign w_term_r = scale_term(r_r,   cr_mix_channel_gain_1);
  assign w_term_o = scale_term(r_osc, cr_mix_channel_gain_2);

  assign w_ch_clip[0] = ~fits({{(OW-PW){w_term_l[PW-1]}}, w_term_l[PW-1:A-1]});
  assign w_ch_clip[1] = ~fits({{(OW-PW){w_term_r[PW-1]}}, w_term_r[PW-1:A-1]});
  assign w_ch_clip[2] = ~fits({{(OW-PW){w_term_o[PW-1]}}, w_term_o[PW-1:A-1]});

  assign w_og_l   = scale_out(r_sum_l, cr_mix_output_gain);
  assign w_og_r   = scale_out(r_sum_r, cr_mix_output_gain);
  assign w_clip_l = ~fits(w_og_l[OW-1:A-1]);
  assign w_clip_r = ~fits(w_og_r[OW-1:A-1]);
  assign w_sat_l  = w_clip_l ? (w_og_l[OW-1] ? MIN_C : MAX_C) : w_og_l[A-1:0];
  assign w_sat_r  = w_clip_r ? (w_og_r[OW-1] ? MIN_C : MAX_C) : w_og_r[A-1:0];

  // State register; r_started keeps adc_ready low until the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= CAP_L;
      r_started <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_started <= 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      CAP_L:   if (w_adc_fire && !adc_last) w_next = CAP_R;  // a stray right word is dropped
      CAP_R:   if (w_adc_fire && adc_last)  w_next = MUL;    // a repeated left word overwrites L
      MUL:     w_next = SUM;
      SUM:     w_next = OGAIN;
      OGAIN:   w_next = OUT_L;
      OUT_L:   if (dac_ready) w_next = OUT_R;
      OUT_R:   if (dac_ready) w_next = CAP_L;
      default: w_next = CAP_L;
    endcase
  end

  always_comb begin
    adc_ready = r_started && (r_state == CAP_L || r_state == CAP_R);
    dac_valid = 1'b0;
    dac_last  = 1'b0;
    dac_data  = '0;
    case (r_state)
      OUT_L: begin
        dac_valid = 1'b1;
        dac_data  = r_out_l;
      end
      OUT_R: begin
        dac_valid = 1'b1;
        dac_last  = 1'b1;
        dac_data  = r_out_r;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_l        <= '0;
      r_r        <= '0;
      r_osc      <= '0;
      r_tl       <= '0;
      r_tr       <= '0;
      r_to       <= '0;
      r_sum_l    <= '0;
      r_sum_r    <= '0;
      r_out_l    <= '0;
      r_out_r    <= '0;
      r_ch_clip  <= '0;
      r_out_clip <= 1'b0;
      r_sr_left  <= '0;
      r_sr_right <= '0;
    end else begin
      if (r_state == CAP_L && w_adc_fire && !adc_last) r_l <= adc_data;
      if (r_state == CAP_R && w_adc_fire) begin
        if (adc_last) begin
          r_r   <= adc_data;
          r_osc <= osc_sample;
        end else begin
          r_l   <= adc_data;
        end
      end
      if (r_state == MUL) begin
        r_tl <= w_term_l;
        r_tr <= w_term_r;
        r_to <= w_term_o;
      end
      if (r_state == SUM) begin
        r_sum_l <= {r_tl[PW-1], r_tl} + {r_to[PW-1], r_to};
        r_sum_r <= {r_tr[PW-1], r_tr} + {r_to[PW-1], r_to};
      end
      if (r_state == OGAIN) begin
        r_out_l <= w_sat_l;
        r_out_r <= w_sat_r;
      end
      // A new clip wins over a coincident clear.
      r_ch_clip  <= (cmd_clear_clip ? 3'b000 : r_ch_clip) |
                    ((r_state == MUL) ? w_ch_clip : 3'b000);
      r_out_clip <= (cmd_clear_clip ? 1'b0 : r_out_clip) |
                    ((r_state == OGAIN) & (w_clip_l | w_clip_r));
      if (r_state == OUT_R && dac_ready) begin
        r_sr_left  <= r_out_l;
        r_sr_right <= r_out_r;
      end
    end
  end

  assign sr_mix_channel_clip = r_ch_clip;
  assign sr_mix_out_clip     = r_out_clip;
  assign sr_mix_out_left     = r_sr_left;
  assign sr_mix_out_right    = r_sr_right;

endmodule

// File: tb/tb_dafx_channel_mixer.sv
// Bench for dafx_channel_mixer: directed scenarios plus randomized frames against an arithmetic model.
// Latency: expects the left output one cycle after the three processing cycles.
// Backpressure: exercises stalled dac_ready and checks adc_ready stays low while a frame is in flight.
module tb_dafx_channel_mixer;

  localparam int A = 24;
  localparam int G = 16;
  localparam int Q = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [A-1:0] adc_data;
  logic         adc_valid;
  logic         adc_ready;
  logic         adc_last;
  logic [A-1:0] osc_sample;
  logic [A-1:0] dac_data;
  logic         dac_valid;
  logic         dac_ready;
  logic         dac_last;
  logic [G-1:0] g0, g1, g2, go;
  logic         cmd_clear_clip;
  logic [2:0]   ch_clip;
  logic         out_clip;
  logic [A-1:0] sr_left, sr_right;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  dafx_channel_mixer dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .adc_data              (adc_data),
    .adc_valid             (adc_valid),
    .adc_ready             (adc_ready),
    .adc_last              (adc_last),
    .osc_sample            (osc_sample),
    .dac_data              (dac_data),
    .dac_valid             (dac_valid),
    .dac_ready             (dac_ready),
    .dac_last              (dac_last),
    .cr_mix_channel_gain_0 (g0),
    .cr_mix_channel_gain_1 (g1),
    .cr_mix_channel_gain_2 (g2),
    .cr_mix_output_gain    (go),
    .cmd_clear_clip        (cmd_clear_clip),
    .sr_mix_channel_clip   (ch_clip),
    .sr_mix_out_clip       (out_clip),
    .sr_mix_out_left       (sr_left),
    .sr_mix_out_right      (sr_right)
  );

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int last_acc = 0;
  logic [2:0] m_cc;   // model sticky channel clip
  logic       m_oc;   // model sticky output clip

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint floor_q(input longint x);
    longint d;
    longint q;
    d = longint'(1) << Q;
    q = x / d;
    if ((x % d) != 0 && x < 0) q = q - 1;
    return q;
  endfunction

  function automatic logic out_of_range(input longint v);
    return (v > 64'sd8388607) || (v < -64'sd8388608);
  endfunction

  function automatic logic [A-1:0] clamp(input longint v);
    logic [63:0] t;
    if (v > 64'sd8388607)  return 24'h7FFFFF;
    if (v < -64'sd8388608) return 24'h800000;
    t = v;
    return t[A-1:0];
  endfunction

  task automatic model(input logic [A-1:0] l, r, o, output logic [A-1:0] el, er,
                       output logic [2:0] cc, output logic oc);
    longint tl, tr, t_o, pl, pr;
    tl  = floor_q(longint'($signed(l)) * longint'(g0));
    tr  = floor_q(longint'($signed(r)) * longint'(g1));
    t_o = floor_q(longint'($signed(o)) * longint'(g2));
    cc  = {out_of_range(t_o), out_of_range(tr), out_of_range(tl)};
    pl  = floor_q((tl + t_o) * longint'(go));
    pr  = floor_q((tr + t_o) * longint'(go));
    oc  = out_of_range(pl) || out_of_range(pr);
    el  = clamp(pl);
    er  = clamp(pr);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic send_word(input logic [A-1:0] d, input logic last);
    bit ok;
    ok = 1'b0;
    adc_data  = d;
    adc_last  = last;
    adc_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (adc_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    adc_valid = 1'b0;
    last_acc  = cyc;
    check("adc_accept", {63'b0, ok}, 64'd1);
  endtask

  // Waits for a frame; the acceptance edge is counted, so OUT_L appears three edges later.
  task automatic recv_frame(input logic [A-1:0] el, er, input int stall, input string tag);
    bit seen;
    int rise;
    seen = 1'b0;
    rise = 0;
    dac_ready = (stall == 0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dac_valid) begin
        seen = 1'b1;
        rise = cyc;
        break;
      end
    end
    check({tag, "_valid_seen"}, {63'b0, seen}, 64'd1);
    check({tag, "_latency"}, 64'(rise - last_acc), 64'd3);
    for (int i = 0; i < stall; i++) begin
      check({tag, "_stall_data"}, {40'b0, dac_data}, {40'b0, el});
      check({tag, "_stall_adc_rdy"}, {62'b0, adc_ready, dac_valid}, 64'd1);
      @(negedge clk);
    end
    dac_ready = 1'b1;
    check({tag, "_left"}, {39'b0, dac_last, dac_data}, {39'b0, 1'b0, el});
    @(posedge clk);
    #1;
    @(negedge clk);
    check({tag, "_right"}, {38'b0, dac_valid, dac_last, dac_data}, {38'b0, 2'b11, er});
    check({tag, "_adc_rdy_in_outr"}, {63'b0, adc_ready}, 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check({tag, "_adc_rdy_after"}, {62'b0, adc_ready, dac_valid}, 64'd2);
    check({tag, "_sr_out"}, {16'b0, sr_left, sr_right}, {16'b0, el, er});
  endtask

  task automatic model_frame(input logic [A-1:0] l, r, o, input int stall, input string tag);
    logic [A-1:0] el, er;
    logic [2:0]   cc;
    logic         oc;
    model(l, r, o, el, er, cc, oc);
    send_word(l, 1'b0);
    osc_sample = o;
    send_word(r, 1'b1);
    recv_frame(el, er, stall, tag);
    m_cc = m_cc | cc;
    m_oc = m_oc | oc;
    check({tag, "_clip"}, {60'b0, ch_clip, out_clip}, {60'b0, m_cc, m_oc});
  endtask

  task automatic pulse_clear();
    cmd_clear_clip = 1'b1;
    @(posedge clk);
    #1;
    cmd_clear_clip = 1'b0;
    m_cc = 3'b000;
    m_oc = 1'b0;
  endtask

  task automatic set_gains(input logic [G-1:0] a, b, c, d);
    g0 = a; g1 = b; g2 = c; go = d;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] rnd;
    logic [A-1:0] rl, rr, ro;
    bit extra;

    rst_n = 1'b0;
    adc_data = '0; adc_valid = 1'b0; adc_last = 1'b0; osc_sample = '0;
    dac_ready = 1'b1; cmd_clear_clip = 1'b0;
    m_cc = 3'b000; m_oc = 1'b0;
    set_gains(16'd256, 16'd256, 16'd256, 16'd256);

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst_adc_ready", {63'b0, adc_ready}, 64'd0);
    check("rst_dac", {38'b0, dac_valid, dac_last, dac_data}, 64'd0);
    check("rst_sr", {12'b0, ch_clip, out_clip, sr_left, sr_right}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("adc_ready_after_rst", {63'b0, adc_ready}, 64'd1);

    // Unity gains, no oscillator
    osc_sample = '0;
    send_word(24'd1000, 1'b0);
    send_word(24'hFFF830, 1'b1);            // -2000
    recv_frame(24'h0003E8, 24'hFFF830, 0, "unity");
    check("unity_noclip", {60'b0, ch_clip, out_clip}, 64'd0);

    // Left channel overflow and sticky clip flags
    set_gains(16'd512, 16'd256, 16'd256, 16'd256);
    send_word(24'h500000, 1'b0);
    send_word(24'h000000, 1'b1);
    recv_frame(24'h7FFFFF, 24'h000000, 0, "clip");
    check("clip_flags", {60'b0, ch_clip, out_clip}, {60'b0, 3'b001, 1'b1});
    pulse_clear();
    @(negedge clk);
    check("clip_cleared", {60'b0, ch_clip, out_clip}, 64'd0);

    // Clear coincident with the MUL cycle that clips: flag must survive
    send_word(24'h500000, 1'b0);
    send_word(24'h000000, 1'b1);
    cmd_clear_clip = 1'b1;
    @(posedge clk);
    #1;
    cmd_clear_clip = 1'b0;
    @(negedge clk);
    check("clear_vs_set", {61'b0, ch_clip}, {61'b0, 3'b001});
    recv_frame(24'h7FFFFF, 24'h000000, 0, "clip2");
    check("clip2_flags", {60'b0, ch_clip, out_clip}, {60'b0, 3'b001, 1'b1});
    pulse_clear();

    // Oscillator with half gain: floor(-50.5) = -51 on both channels
    set_gains(16'd256, 16'd256, 16'd128, 16'd256);
    send_word(24'd0, 1'b0);
    osc_sample = 24'hFFFF9B;                // -101
    send_word(24'd0, 1'b1);
    recv_frame(24'hFFFFCD, 24'hFFFFCD, 0, "osc_floor");

    // Output backpressure for 10 cycles
    set_gains(16'd256, 16'd256, 16'd256, 16'd256);
    osc_sample = '0;
    send_word(24'h123456, 1'b0);
    send_word(24'hFEDCBA, 1'b1);
    recv_frame(24'h123456, 24'hFEDCBA, 10, "stall");

    // Framing resync: stray right word dropped, repeated left overwrites
    send_word(24'd7, 1'b1);
    send_word(24'd1, 1'b0);
    send_word(24'd2, 1'b0);
    send_word(24'd3, 1'b1);
    recv_frame(24'd2, 24'd3, 0, "resync");
    extra = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dac_valid) extra = 1'b1;
    end
    check("resync_single_frame", {63'b0, extra}, 64'd0);

    // Reset while the frame sits in OGAIN (with clip flags set by its MUL stage)
    set_gains(16'd512, 16'd256, 16'd256, 16'd256);
    send_word(24'h500000, 1'b0);
    send_word(24'd5, 1'b1);
    @(posedge clk);
    #1;                                     // SUM
    @(posedge clk);
    #1;                                     // OGAIN
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", {37'b0, adc_ready, dac_valid, dac_last, dac_data}, 64'd0);
    check("midrst_sr", {12'b0, ch_clip, out_clip, sr_left, sr_right}, 64'd0);
    m_cc = 3'b000;
    m_oc = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    extra = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (dac_valid) extra = 1'b1;
    end
    check("midrst_no_frame", {63'b0, extra}, 64'd0);
    set_gains(16'd256, 16'd256, 16'd256, 16'd256);
    model_frame(24'd77, 24'hFFFF00, 24'd3, 0, "post_rst");

    // Randomized frames against the model
    for (int f = 0; f < 30; f++) begin
      rnd = $urandom(); rl = rnd[A-1:0];
      rnd = $urandom(); rr = rnd[A-1:0];
      rnd = $urandom(); ro = rnd[A-1:0];
      if ($urandom_range(0, 1) == 0) begin
        rl = {{8{rl[15]}}, rl[15:0]};
        ro = {{8{ro[15]}}, ro[15:0]};
      end
      g0 = 16'($urandom_range(0, 700));
      g1 = 16'($urandom_range(0, 700));
      g2 = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom_range(0, 400));
      go = 16'($urandom_range(0, 600));
      if ($urandom_range(0, 3) == 0) pulse_clear();
      model_frame(rl, rr, ro, $urandom_range(0, 3), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks so far", n_total);
    $fatal(1, "watchdog");
  end

endmodule
